// File: rtl/kudu_mem_cmd_mon.sv
// kudu_mem_cmd_mon: passive monitor on the core data-memory interface.
// Pairs every granted request with its in-order response, builds one
// mem_cmd_t record per completed transaction and buffers the records in a
// show-ahead FIFO that a DV checker drains through a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   data_*_i                observed bus (request, grant, response)
//   cmd_valid_o/cmd_ready_i record handshake towards the consumer
//   cmd_o                   FIFO head record (zero while the FIFO is empty)
//   drop_cnt_o              saturating count of records lost to a full FIFO
//   proto_err_o             sticky bus-protocol violation flag

package kudu_dv_pkg;

    // One completed bus transaction (175 bits).
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic        is_cap;
        logic [29:0] addr32;
        logic [64:0] wdata;
        logic [64:0] rdata;
        logic        err;
        logic [7:0]  flag;   // [7:3] grant seq, [2] misaligned, [1] tag map, [0] DRAM
    } mem_cmd_t;

endpackage

module kudu_mem_cmd_mon
    import kudu_dv_pkg::*;
#(
    parameter int unsigned OutstandingDepth = 2,
    parameter int unsigned FifoDepth        = 8,
    parameter logic [31:0] DRAMStartAddr    = 32'h8000_0000,
    parameter logic [31:0] TsMapStartAddr   = 32'h8300_0000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           data_req_i,
    input  logic           data_gnt_i,
    input  logic           data_we_i,
    input  logic [3:0]     data_be_i,
    input  logic [31:0]    data_addr_i,
    input  logic           data_is_cap_i,
    input  logic [64:0]    data_wdata_i,
    input  logic           data_rvalid_i,
    input  logic [64:0]    data_rdata_i,
    input  logic           data_err_i,
    output logic           cmd_valid_o,
    input  logic           cmd_ready_i,
    output mem_cmd_t       cmd_o,
    output logic [15:0]    drop_cnt_o
    ,
    output logic           proto_err_o
);

    localparam int unsigned PIW = (OutstandingDepth > 1) ? $clog2(OutstandingDepth) : 1;
    localparam int unsigned FIW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    // Pointers are {wrap, index}; the wrap bit separates full from empty.
    logic [PIW:0] pend_wr, pend_rd;
    logic [FIW:0] fifo_wr, fifo_rd;
    logic [4:0]   seq;

    mem_cmd_t pend_mem [OutstandingDepth];
    mem_cmd_t fifo_mem [FifoDepth];

    logic     pend_empty, pend_full, fifo_empty, fifo_full;
    logic     pend_pop, pend_push, fifo_pop, fifo_push, drop, proto_set;
    mem_cmd_t new_rec, done_rec;

    function automatic logic [PIW:0] pend_next(input logic [PIW:0] p);
        if (p[PIW-1:0] == PIW'(OutstandingDepth - 1)) return {~p[PIW], PIW'(0)};
        return {p[PIW], p[PIW-1:0] + PIW'(1)};
    endfunction

    function automatic logic [FIW:0] fifo_next(input logic [FIW:0] p);
        if (p[FIW-1:0] == FIW'(FifoDepth - 1)) return {~p[FIW], FIW'(0)};
        return {p[FIW], p[FIW-1:0] + FIW'(1)};
    endfunction

    assign pend_empty = (pend_wr == pend_rd);
    assign pend_full  = (pend_wr[PIW-1:0] == pend_rd[PIW-1:0]) && (pend_wr[PIW] != pend_rd[PIW]);
    assign fifo_empty = (fifo_wr == fifo_rd);
    assign fifo_full  = (fifo_wr[FIW-1:0] == fifo_rd[FIW-1:0]) && (fifo_wr[FIW] != fifo_rd[FIW]);

    // Handshake decisions; a same-cycle pop always frees the slot for a push.
    always_comb begin
        pend_pop  = data_rvalid_i && !pend_empty;
        pend_push = data_req_i && data_gnt_i && (!pend_full || pend_pop);
        fifo_pop  = !fifo_empty && cmd_ready_i;
        fifo_push = pend_pop && (!fifo_full || fifo_pop);
        drop      = pend_pop && fifo_full && !fifo_pop;
        proto_set = (data_rvalid_i && pend_empty) ||
                    (data_req_i && data_gnt_i && pend_full && !pend_pop);
    end

    // Address-phase record and completed record.
    always_comb begin
        new_rec         = '0;
        new_rec.we      = data_we_i;
        new_rec.be      = data_be_i;
        new_rec.is_cap  = data_is_cap_i;
        new_rec.addr32  = data_addr_i[31:2];
        new_rec.wdata   = data_wdata_i;
        new_rec.flag[0] = (data_addr_i >= DRAMStartAddr) && (data_addr_i < TsMapStartAddr);
        new_rec.flag[1] = (data_addr_i >= TsMapStartAddr);
        new_rec.flag[2] = (data_addr_i[1:0] != 2'b00) ||
                          (data_is_cap_i && (data_addr_i[2:0] != 3'b000));
        new_rec.flag[7:3] = seq;

        done_rec       = pend_mem[pend_rd[PIW-1:0]];
        done_rec.rdata = done_rec.we ? 65'(0) : data_rdata_i;
        done_rec.err   = data_err_i;
    end

    // Pointers, sequence number and status counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_wr     <= '0;
            pend_rd     <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            seq         <= '0;
            drop_cnt_o  <= '0;
            proto_err_o <= 1'b0;
        end else begin
            if (pend_push) begin
                pend_wr <= pend_next(pend_wr);
                seq     <= seq + 5'(1);
            end
            if (pend_pop)  pend_rd <= pend_next(pend_rd);
            if (fifo_push) fifo_wr <= fifo_next(fifo_wr);
            if (fifo_pop)  fifo_rd <= fifo_next(fifo_rd);
            if (drop && (drop_cnt_o != 16'hFFFF)) drop_cnt_o <= drop_cnt_o + 16'(1);
            if (proto_set) proto_err_o <= 1'b1;
        end
    end

    // Storage arrays; validity is carried entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (pend_push) pend_mem[pend_wr[PIW-1:0]] <= new_rec;
        if (fifo_push) fifo_mem[fifo_wr[FIW-1:0]] <= done_rec;
    end

    assign cmd_valid_o = !fifo_empty;
    assign cmd_o       = fifo_empty ? '0 : fifo_mem[fifo_rd[FIW-1:0]];

endmodule

// File: tb/tb_kudu_mem_cmd_mon.sv
// Directed self-checking bench for kudu_mem_cmd_mon.
module tb_kudu_mem_cmd_mon;
    import kudu_dv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        data_req_i, data_gnt_i, data_we_i, data_is_cap_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [64:0] data_wdata_i, data_rdata_i;
    logic        data_rvalid_i, data_err_i;
    logic        cmd_valid_o, cmd_ready_i;
    mem_cmd_t    cmd_o;
    logic [15:0] drop_cnt_o;
    logic        proto_err_o;

    int checks = 0;
    int errors = 0;

    kudu_mem_cmd_mon #(.OutstandingDepth(2), .FifoDepth(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .data_req_i(data_req_i), .data_gnt_i(data_gnt_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_is_cap_i(data_is_cap_i),
        .data_wdata_i(data_wdata_i), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_o(cmd_o),
        .drop_cnt_o(drop_cnt_o), .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        data_req_i = 0; data_gnt_i = 0; data_we_i = 0; data_be_i = 4'h0;
        data_addr_i = 32'h0; data_is_cap_i = 0; data_wdata_i = '0;
        data_rvalid_i = 0; data_rdata_i = '0; data_err_i = 0;
    endtask

    task automatic apply_reset();
        bus_idle();
        cmd_ready_i = 0;
        rst_i = 1;
        step(); step();
        rst_i = 0;
        step();
    endtask

    task automatic grant_read(input logic [31:0] addr);
        data_req_i = 1; data_gnt_i = 1; data_we_i = 0; data_be_i = 4'hF;
        data_is_cap_i = 0; data_addr_i = addr; data_wdata_i = '0;
    endtask

    // Expected record for the i-th read of do_reads, granted with sequence s.
    function automatic mem_cmd_t rd_rec(input int i, input int s);
        mem_cmd_t r;
        r        = '0;
        r.be     = 4'hF;
        r.addr32 = 30'h2000_0000 + 30'(i);
        r.rdata  = 65'(i);
        r.flag   = {5'(s), 3'b001};
        return r;
    endfunction

    // n pipelined DRAM reads: read i at 8000_0000+4i answered next cycle with rdata=i.
    task automatic do_reads(input int n);
        for (int i = 0; i <= n; i++) begin
            if (i < n) grant_read(32'h8000_0000 + 32'(4 * i));
            else begin data_req_i = 0; data_gnt_i = 0; end
            data_rvalid_i = (i > 0);
            data_rdata_i  = (i > 0) ? 65'(i - 1) : '0;
            step();
        end
        bus_idle();
    endtask

    task automatic test_reset();
        bus_idle();
        cmd_ready_i = 0;
        rst_i = 1;
        #1;
        checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cmd_valid_o); end
        checks++; if (cmd_o !== '0) begin errors++; $display("FAIL reset_cmd: got %h expected 0", cmd_o); end
        checks++; if (drop_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_drop: got %h expected 0", drop_cnt_o); end
        checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL reset_proto: got %b expected 0", proto_err_o); end
        step(); step();
        rst_i = 0;
        step();
    endtask

    task automatic test_single_read();
        mem_cmd_t e;
        apply_reset();
        grant_read(32'h8000_0010);
        step();
        bus_idle();
        step();
        data_rvalid_i = 1; data_rdata_i = 65'h1_DEAD_BEEF;
        step();
        bus_idle();
        e = '0; e.be = 4'hF; e.addr32 = 30'h2000_0004; e.rdata = 65'h1_DEAD_BEEF; e.flag = 8'h01;
        checks++; if (cmd_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", cmd_valid_o); end
        checks++; if (cmd_o !== e) begin errors++; $display("FAIL single_rec: got %h expected %h", cmd_o, e); end
        cmd_ready_i = 1;
        step();
        cmd_ready_i = 0;
        checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", cmd_valid_o); end
    endtask

    task automatic test_back_to_back();
        mem_cmd_t e1, e2;
        apply_reset();
        data_req_i = 1; data_gnt_i = 1; data_we_i = 1; data_be_i = 4'hF; data_is_cap_i = 1;
        data_addr_i = 32'h8300_0008; data_wdata_i = 65'h1_1234_5678;
        step();
        data_we_i = 0; data_be_i = 4'h3; data_is_cap_i = 0;
        data_addr_i = 32'h8000_0002; data_wdata_i = '0;
        step();
        data_req_i = 0; data_gnt_i = 0;
        data_rvalid_i = 1; data_rdata_i = 65'h0_AAAA_5555;
        step();
        data_rdata_i = 65'h0_CAFE_F00D; data_err_i = 1;
        step();
        bus_idle();
        e1 = '0; e1.we = 1; e1.be = 4'hF; e1.is_cap = 1; e1.addr32 = 30'h20C0_0002;
        e1.wdata = 65'h1_1234_5678; e1.flag = 8'h02;
        e2 = '0; e2.be = 4'h3; e2.addr32 = 30'h2000_0000; e2.rdata = 65'h0_CAFE_F00D;
        e2.err = 1; e2.flag = 8'h0D;
        checks++; if (cmd_o !== e1) begin errors++; $display("FAIL b2b_write: got %h expected %h", cmd_o, e1); end
        cmd_ready_i = 1;
        step();
        checks++; if (cmd_o !== e2) begin errors++; $display("FAIL b2b_read: got %h expected %h", cmd_o, e2); end
        step();
        cmd_ready_i = 0;
        checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", cmd_valid_o); end
    endtask

    task automatic test_backpressure_overflow();
        apply_reset();
        do_reads(10);
        checks++; if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL ovf_drop: got %0d expected 2", drop_cnt_o); end
        checks++; if (cmd_valid_o !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", cmd_valid_o); end
        checks++; if (cmd_o !== rd_rec(0, 0)) begin errors++; $display("FAIL ovf_head_stable: got %h expected %h", cmd_o, rd_rec(0, 0)); end
        cmd_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (cmd_valid_o !== 1'b1 || cmd_o !== rd_rec(i, i)) begin
                errors++; $display("FAIL ovf_drain_%0d: got v=%b %h expected v=1 %h", i, cmd_valid_o, cmd_o, rd_rec(i, i));
            end
            step();
        end
        cmd_ready_i = 0;
        checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", cmd_valid_o); end
        checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL ovf_proto: got %b expected 0", proto_err_o); end
    endtask

    task automatic test_full_same_cycle_pop();
        apply_reset();
        do_reads(8);
        grant_read(32'h8000_0020);
        step();
        bus_idle();
        data_rvalid_i = 1; data_rdata_i = 65'd8; cmd_ready_i = 1;
        step();
        data_rvalid_i = 0; cmd_ready_i = 0;
        checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL fullpop_drop: got %0d expected 0", drop_cnt_o); end
        cmd_ready_i = 1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (cmd_valid_o !== 1'b1 || cmd_o !== rd_rec(i, i)) begin
                errors++; $display("FAIL fullpop_drain_%0d: got v=%b %h expected v=1 %h", i, cmd_valid_o, cmd_o, rd_rec(i, i));
            end
            step();
        end
        cmd_ready_i = 0;
        checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got %b expected 0", cmd_valid_o); end
    endtask

    task automatic test_proto_err();
        apply_reset();
        data_rvalid_i = 1; data_rdata_i = 65'h5;
        step();
        bus_idle();
        checks++; if (proto_err_o !== 1'b1) begin errors++; $display("FAIL proto_orphan: got %b expected 1", proto_err_o); end
        checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL proto_no_rec: got %b expected 0", cmd_valid_o); end
        grant_read(32'h8000_0000); step();
        grant_read(32'h8000_0004); step();
        grant_read(32'h8000_0008); step();   // queue full: discarded
        bus_idle();
        data_rvalid_i = 1; data_rdata_i = 65'd0; step();
        data_rdata_i = 65'd1; step();
        bus_idle();
        grant_read(32'h8000_0008); step();
        bus_idle();
        data_rvalid_i = 1; data_rdata_i = 65'd2; step();
        bus_idle();
        cmd_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (cmd_valid_o !== 1'b1 || cmd_o !== rd_rec(i, i)) begin
                errors++; $display("FAIL proto_rec_%0d: got v=%b %h expected v=1 %h", i, cmd_valid_o, cmd_o, rd_rec(i, i));
            end
            step();
        end
        cmd_ready_i = 0;
        checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL proto_extra_rec: got %b expected 0", cmd_valid_o); end
        checks++; if (proto_err_o !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b expected 1", proto_err_o); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_reads(3);
        grant_read(32'h8000_0100); step();
        grant_read(32'h8000_0104); step();
        bus_idle();
        checks++; if (cmd_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", cmd_valid_o); end
        rst_i = 1;
        #1;
        checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", cmd_valid_o); end
        checks++; if (cmd_o !== '0) begin errors++; $display("FAIL rstmid_cmd: got %h expected 0", cmd_o); end
        step();
        rst_i = 0;
        step();
        grant_read(32'h8000_0010); step();
        bus_idle();
        data_rvalid_i = 1; data_rdata_i = 65'h1_DEAD_BEEF; step();
        bus_idle();
        checks++; if (cmd_valid_o !== 1'b1 || cmd_o.flag !== 8'h01) begin
            errors++; $display("FAIL rstmid_seq0: got v=%b flag=%h expected v=1 flag=01", cmd_valid_o, cmd_o.flag);
        end
        cmd_ready_i = 1; step(); cmd_ready_i = 0;
        checks++; if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got %b expected 0", cmd_valid_o); end
        checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL rstmid_drop: got %0d expected 0", drop_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_backpressure_overflow();
        test_full_same_cycle_pop();
        test_proto_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
